// File: rtl/addd_accumulator_if.sv
// ----------------------------------------------------------------------------
// addd_accumulator_if
//   Bundles the beat-in / sum-out handshake of addd_accumulator.
//   master : the surrounding logic (adder side + writeback consumer)
//   slave  : the accumulator block itself
// Signals:
//   start, len            - operation request and beat count
//   in_valid/in_ready     - beat handshake, res_high:res_low is the 64-bit beat
//   out_valid/out_ready   - sum handshake, acc_high:acc_low is the 64-bit total
//   overflow              - sticky signed overflow of the current operation
//   busy, beats_left      - status
// ----------------------------------------------------------------------------
interface addd_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      res_high;
  logic [31:0]      res_low;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      acc_high;
  logic [31:0]      acc_low;
  logic             overflow;
  logic             busy;
  logic [CNT_W-1:0] beats_left;

  modport master (
    output start, len, in_valid, res_high, res_low, out_ready,
    input  in_ready, out_valid, acc_high, acc_low, overflow, busy, beats_left
  );

  modport slave (
    input  start, len, in_valid, res_high, res_low, out_ready,
    output in_ready, out_valid, acc_high, acc_low, overflow, busy, beats_left
  );
endinterface

// File: rtl/addd_accumulator.sv
// ----------------------------------------------------------------------------
// addd_accumulator
//   Sums a programmed number of 64-bit adder results into a 64-bit signed
//   accumulator, then holds the total (with a sticky signed-overflow flag)
//   until the consumer takes it.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - addd_accumulator_if.slave (start/len, beat handshake, sum
//           handshake, overflow, busy, beats_left)
// ----------------------------------------------------------------------------
module addd_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addd_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] beats_left_q, beats_left_d;

  logic [63:0]      addend;
  logic [63:0]      sum;
  logic             add_ovf;
  logic             beat_fire;

  assign addend    = {bus.res_high, bus.res_low};
  assign sum       = acc_q + addend;
  // Signed overflow: operands agree in sign but the result does not.
  assign add_ovf   = (acc_q[63] == addend[63]) && (sum[63] != acc_q[63]);
  assign beat_fire = (state_q == S_ACCUM) && bus.in_valid;

  // NOTE: every variable gets its hold value before the case statement, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    beats_left_d = beats_left_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d        = '0;
          ovf_d        = 1'b0;
          beats_left_d = bus.len;
          state_d      = (bus.len != '0) ? S_ACCUM : S_DONE;
        end
      end

      S_ACCUM: begin
        if (beat_fire) begin
          acc_d        = sum;
          ovf_d        = ovf_q | add_ovf;
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == CNT_W'(1)) state_d = S_DONE;
        end
      end

      S_DONE: begin
        // start is deliberately ignored here, even alongside out_ready.
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Handshake/status outputs decode state only: no combinational path from
  // in_valid or out_ready.
  assign bus.in_ready   = (state_q == S_ACCUM);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.acc_high   = acc_q[63:32];
  assign bus.acc_low    = acc_q[31:0];
  assign bus.overflow   = ovf_q;
  assign bus.beats_left = beats_left_q;

endmodule
